// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT row/column sequencers.
package dct_pkg;

  localparam int unsigned ROW_LEN      = 8;
  localparam int unsigned ROWS_PER_BLK = 8;
  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned COL_W        = $clog2(ROW_LEN);
  localparam int unsigned ROW_W        = $clog2(ROWS_PER_BLK);

  localparam logic [SAMPLE_W-1:0] LSHIFT_MASK = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT,
    BLK_END
  } state_t;

  // Lane 0 holds the first sample of the row.
  typedef logic [ROW_LEN-1:0][SAMPLE_W-1:0] row_t;

  // Unsigned pixel to two's-complement by flipping the MSB (x - 128).
  function automatic logic [SAMPLE_W-1:0] level_shift(input logic [SAMPLE_W-1:0] d,
                                                      input bit en);
    return en ? (d ^ LSHIFT_MASK) : d;
  endfunction

endpackage

// File: rtl/dct_row_seq_if.sv
// Pixel stream and row-datapath handshake bundle for the DCT row sequencer.
interface dct_row_seq_if;
  import dct_pkg::*;

  logic                 s_valid;
  logic [SAMPLE_W-1:0]  s_data;
  logic                 s_ready;
  logic                 dp_start;
  row_t                 dp_row;
  logic [ROW_W-1:0]     dp_row_idx;
  logic                 dp_done;

  modport master (
    input  s_valid, s_data, dp_done,
    output s_ready, dp_start, dp_row, dp_row_idx
  );

  modport slave (
    output s_valid, s_data, dp_done,
    input  s_ready, dp_start, dp_row, dp_row_idx
  );

endinterface

// File: rtl/dct_wdog.sv
// Loadable up-counter with clear/enable; tc_c flags the TIMEOUT-1 terminal count.
module dct_wdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt;

  // Clear has priority over load, load over count.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign tc_c = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/dct_row_seq.sv
// Row sequencer: packs pixels into 8-sample rows, launches them into the 1-D DCT
// datapath, counts rows per 8x8 block and aborts a block when the datapath stalls.
module dct_row_seq
  import dct_pkg::*;
#(
  parameter bit          LSHIFT  = 1'b1,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  dct_row_seq_if.master     bus,
  output logic              blk_done,
  output logic [CNT_W-1:0]  blk_cnt,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int unsigned WD_W = 16;

  state_t             state, state_next;
  logic [COL_W-1:0]   col, col_next;
  logic [ROW_W-1:0]   row, row_next;
  row_t               buf_q, buf_next;
  logic [CNT_W-1:0]   blk_cnt_next;
  logic               err_next;
  logic               timeout;
  logic               wd_tc;

  dct_wdog #(
    .TIMEOUT (TIMEOUT),
    .W       (WD_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == ISSUE),
    .en       (state == WAIT),
    .load     (1'b0),
    .load_val (WD_W'(0)),
    .tc_c     (wd_tc)
  );

  // Next-state and datapath bookkeeping.
  always_comb begin
    state_next   = state;
    col_next     = col;
    row_next     = row;
    buf_next     = buf_q;
    blk_cnt_next = blk_cnt;
    err_next     = err;
    timeout      = 1'b0;

    case (state)
      FILL: begin
        if (bus.s_valid) begin
          buf_next[col] = level_shift(bus.s_data, LSHIFT);
          if (col == COL_W'(ROW_LEN - 1)) begin
            col_next   = '0;
            state_next = ISSUE;
          end else begin
            col_next = col + COL_W'(1);
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        // A done pulse on the terminal-count cycle still counts as success.
        if (bus.dp_done) begin
          if (row == ROW_W'(ROWS_PER_BLK - 1)) begin
            row_next     = '0;
            blk_cnt_next = blk_cnt + CNT_W'(1);
            state_next   = BLK_END;
          end else begin
            row_next   = row + ROW_W'(1);
            state_next = FILL;
          end
        end else if (wd_tc) begin
          timeout    = 1'b1;
          row_next   = '0;
          col_next   = '0;
          state_next = FILL;
        end
      end
      BLK_END: state_next = FILL;
      default: state_next = FILL;
    endcase

    if (err_clr) err_next = 1'b0;
    if (timeout) err_next = 1'b1;
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      col            <= '0;
      row            <= '0;
      buf_q          <= '0;
      bus.s_ready    <= 1'b1;
      bus.dp_start   <= 1'b0;
      bus.dp_row     <= '0;
      bus.dp_row_idx <= '0;
      blk_done       <= 1'b0;
      blk_cnt        <= '0;
      busy           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state        <= state_next;
      col          <= col_next;
      row          <= row_next;
      buf_q        <= buf_next;
      blk_cnt      <= blk_cnt_next;
      err          <= err_next;
      bus.s_ready  <= (state_next == FILL);
      bus.dp_start <= (state_next == ISSUE);
      blk_done     <= (state_next == BLK_END);
      busy         <= (state_next != FILL) || (col_next != '0) || (row_next != '0);
      // The row handed to the datapath stays frozen while the next one fills.
      if (state_next == ISSUE) begin
        bus.dp_row     <= buf_next;
        bus.dp_row_idx <= row;
      end
    end
  end

endmodule

// File: tb/tb_dct_row_seq.sv
// Directed bench for dct_row_seq: single row, full block, input gaps, watchdog,
// done/timeout races and reset mid-WAIT.
module tb_dct_row_seq;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_clr1 = 1'b0;

  logic        blk_done0, busy0, err0;
  logic [15:0] blk_cnt0;
  logic        blk_done1, busy1, err1;
  logic [15:0] blk_cnt1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;
  int n_blk = 0;
  int ready_lo = 0;
  int c0;

  dct_row_seq_if if0();
  dct_row_seq_if if1();

  dct_row_seq #(.LSHIFT(1'b1), .TIMEOUT(8), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master),
    .blk_done(blk_done0), .blk_cnt(blk_cnt0), .busy(busy0),
    .err(err0), .err_clr(err_clr)
  );

  dct_row_seq #(.LSHIFT(1'b0), .TIMEOUT(64), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master),
    .blk_done(blk_done1), .blk_cnt(blk_cnt1), .busy(busy1),
    .err(err1), .err_clr(err_clr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.dp_start) n_start++;
    if (blk_done0) n_blk++;
    if (!if0.s_ready) ready_lo++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Eight back-to-back samples on if0; returns at the ISSUE-cycle negedge.
  task automatic feed8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      if0.s_valid = 1'b1;
      if0.s_data  = base + 8'(i);
      tick();
    end
    if0.s_valid = 1'b0;
  endtask

  // Pulse dp_done lat cycles after dp_start; returns one cycle after the pulse.
  task automatic done_after(input int lat);
    repeat (lat) tick();
    if0.dp_done = 1'b1;
    tick();
    if0.dp_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.s_valid = 1'b0; if0.s_data = '0; if0.dp_done = 1'b0;
    if1.s_valid = 1'b0; if1.s_data = '0; if1.dp_done = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_s_ready",  64'(if0.s_ready),    64'd1);
    check("rst_dp_start", 64'(if0.dp_start),   64'd0);
    check("rst_dp_row",   64'(if0.dp_row),     64'd0);
    check("rst_idx",      64'(if0.dp_row_idx), 64'd0);
    check("rst_blk_done", 64'(blk_done0),      64'd0);
    check("rst_blk_cnt",  64'(blk_cnt0),       64'd0);
    check("rst_err",      64'(err0),           64'd0);
    check("rst_busy",     64'(busy0),          64'd0);

    // Single row, level-shifted, datapath latency 3
    ready_lo = 0;
    n_start  = 0;
    feed8(8'h00);
    check("row_start",   64'(if0.dp_start),   64'd1);
    check("row_data",    64'(if0.dp_row),     64'h8786858483828180);
    check("row_idx",     64'(if0.dp_row_idx), 64'd0);
    check("row_busy",    64'(busy0),          64'd1);
    done_after(3);
    check("row_ready_back", 64'(if0.s_ready),  64'd1);
    check("row_ready_lo",   64'(ready_lo),     64'd4);
    check("row_n_start",    64'(n_start),      64'd1);
    check("row_held",       64'(if0.dp_row),   64'h8786858483828180);
    check("row_start_low",  64'(if0.dp_start), 64'd0);

    // Full block at full rate, latency 2: 11 cycles per row plus BLK_END
    do_reset();
    n_start = 0;
    n_blk   = 0;
    c0      = cyc;
    for (int r = 0; r < 8; r++) begin
      feed8(8'(r * 8));
      check("blk_idx", 64'(if0.dp_row_idx), 64'(r));
      done_after(2);
    end
    check("blk_done_pulse", 64'(blk_done0),     64'd1);
    check("blk_cnt_one",    64'(blk_cnt0),      64'd1);
    check("blk_cycles",     64'(cyc - c0),      64'd88);
    check("blk_ready_low",  64'(if0.s_ready),   64'd0);
    check("blk_last_row",   64'(if0.dp_row),    64'hBFBEBDBCBBBAB9B8);
    tick();
    check("blk_done_end",   64'(blk_done0),     64'd0);
    check("blk_cnt_hold",   64'(blk_cnt0),      64'd1);
    check("blk_n_start",    64'(n_start),       64'd8);
    check("blk_n_blk",      64'(n_blk),         64'd1);
    check("blk_idle_ready", 64'(if0.s_ready),   64'd1);
    check("blk_idle_busy",  64'(busy0),         64'd0);

    // Alternating valid gaps on the raw (no level shift) instance
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if1.s_valid = 1'b1;
      if1.s_data  = 8'h10 + 8'(i);
      tick();
      if1.s_valid = 1'b0;
      if1.s_data  = 8'hEE;
      tick();
    end
    check("gap_row",   64'(if1.dp_row),     64'h1716151413121110);
    check("gap_idx",   64'(if1.dp_row_idx), 64'd0);
    check("gap_ready", 64'(if1.s_ready),    64'd0);
    if1.dp_done = 1'b1;
    tick();
    if1.dp_done = 1'b0;
    check("gap_back",    64'(if1.s_ready), 64'd1);
    check("gap_busy",    64'(busy1),       64'd1);
    check("gap_err",     64'(err1),        64'd0);
    check("gap_blk",     64'(blk_cnt1),    64'd0);
    check("gap_blkdone", 64'(blk_done1),   64'd0);

    // Watchdog: TIMEOUT=8, stall on row 3
    do_reset();
    for (int r = 0; r < 3; r++) begin
      feed8(8'(r * 8));
      done_after(2);
    end
    feed8(8'h18);
    check("wd_idx3", 64'(if0.dp_row_idx), 64'd3);
    repeat (8) tick();
    check("wd_pre",   64'(err0),        64'd0);
    tick();
    check("wd_err",   64'(err0),        64'd1);
    check("wd_ready", 64'(if0.s_ready), 64'd1);
    check("wd_blk",   64'(blk_cnt0),    64'd0);
    check("wd_busy",  64'(busy0),       64'd0);
    feed8(8'h40);
    check("wd_idx0",  64'(if0.dp_row_idx), 64'd0);
    done_after(2);
    check("wd_sticky", 64'(err0), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_clr", 64'(err0), 64'd0);
    // Clear and a fresh timeout in the same cycle: the set wins
    feed8(8'h48);
    check("wd_idx1", 64'(if0.dp_row_idx), 64'd1);
    repeat (8) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_race_err",   64'(err0),        64'd1);
    check("clr_race_ready", 64'(if0.s_ready), 64'd1);

    // Races: dp_done during ISSUE, and dp_done on the terminal-count cycle
    do_reset();
    feed8(8'h00);
    if0.dp_done = 1'b1;
    tick();
    if0.dp_done = 1'b0;
    check("iss_race_wait1", 64'(if0.s_ready), 64'd0);
    tick();
    check("iss_race_wait2", 64'(if0.s_ready), 64'd0);
    if0.dp_done = 1'b1;
    tick();
    if0.dp_done = 1'b0;
    check("iss_race_back", 64'(if0.s_ready), 64'd1);
    feed8(8'h08);
    check("iss_race_idx", 64'(if0.dp_row_idx), 64'd1);
    repeat (8) tick();
    if0.dp_done = 1'b1;
    tick();
    if0.dp_done = 1'b0;
    check("tc_race_err",   64'(err0),        64'd0);
    check("tc_race_ready", 64'(if0.s_ready), 64'd1);
    feed8(8'h10);
    check("tc_race_idx", 64'(if0.dp_row_idx), 64'd2);
    done_after(1);

    // Reset while waiting on row 5, followed by a stale dp_done
    do_reset();
    for (int r = 0; r < 5; r++) begin
      feed8(8'(r * 8));
      done_after(1);
    end
    feed8(8'h28);
    check("mid_idx5", 64'(if0.dp_row_idx), 64'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if0.dp_done = 1'b1;
    tick();
    if0.dp_done = 1'b0;
    check("mid_ready", 64'(if0.s_ready), 64'd1);
    check("mid_blk",   64'(blk_cnt0),    64'd0);
    check("mid_busy",  64'(busy0),       64'd0);
    check("mid_err",   64'(err0),        64'd0);
    feed8(8'h00);
    check("mid_start", 64'(if0.dp_start),   64'd1);
    check("mid_idx0",  64'(if0.dp_row_idx), 64'd0);
    done_after(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
